fifo_512_unpack: RTL and testbench
==================================

# fifo_512_unpack

Read-side companion of the 512-bit buffering FIFO. It pops 512-bit words from the FIFO, which has a one-cycle read latency and is not first-word-fall-through, and serializes each word into OUT_W-bit beats on a valid/ready stream. It sits between the FIFO read port and narrower downstream consumers. It prefetches one word so the output stream is gapless while the FIFO holds data.

## Interface
- OUT_W, default 64: output beat width; legal values 8, 16, 32, 64, 128, 256 (512 % OUT_W == 0, BEATS = 512/OUT_W ≥ 2).
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- fifo_dout  in  512  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop request.
- m_data  out  OUT_W  output beat.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accept; a beat transfers when m_valid && m_ready.
- m_last  out  1  high on the final beat of each 512-bit word.

## Operation
- State registers:
  - active word (512 b) with beat counter cnt (0..BEATS-1) and active_v;
  - stage word (512 b) with stage_v;
  - pending (a read is in flight).
- fifo_rd_en = !rst && !fifo_empty && !pending && !stage_v.
  - Combinational from registered state and fifo_empty.
  - Never high while fifo_empty = 1.
- pending <= fifo_rd_en each cycle.
- Active word frees when active_v = 0, or when the last beat (cnt = BEATS-1) transfers this cycle.
- Load priority when the active word frees:
  - If stage_v is set, stage moves to active and stage_v clears.
  - Otherwise, if pending is set, fifo_dout loads directly into active (bypass).
- If pending is set and the return is not consumed by the active slot, fifo_dout is captured into stage and stage_v is set.
- Both cases together (stage moves to active while pending returns): fifo_dout goes to stage. No word is lost or duplicated.
- Beat order is little-endian: m_data = active[cnt*OUT_W +: OUT_W]. Beat 0 is bits [OUT_W-1:0].
- m_valid = active_v. m_last = active_v && cnt == BEATS-1.
- On a transfer, cnt increments. On the last beat, cnt wraps to 0 and the next word loads in the same edge, or active_v clears.
- With m_ready = 0, m_data, m_valid and m_last hold stable. No further reads are issued once stage_v is set.
- Word order out equals FIFO pop order.

## Timing
- Reset values: fifo_rd_en = 0, m_valid = 0, m_last = 0, m_data = 0. Internally active_v = stage_v = pending = 0 and cnt = 0.
- Reset mid-word:
  - the partial word, the staged word and any in-flight read are discarded;
  - the FIFO must be reset in the same cycle.
- First-word latency: fifo_rd_en high in cycle N → fifo_dout captured at the end of N+1 → m_valid high in cycle N+2 with beat 0.
- Throughput: with m_ready held at 1 and the FIFO continuously non-empty, m_valid stays high every cycle after the first, giving one beat per clock and no bubbles between words (for BEATS ≥ 2).
- Maximum words held inside the block is 2 (active + stage). At most 1 read is outstanding.
- If the FIFO goes empty, m_valid drops after the last held beat transfers. It rises again 2 cycles after the next fifo_rd_en.

## Structure
- Shared package holds:
  - WORD_W = 512;
  - the legal-OUT_W check (elaboration assertion BEATS ≥ 2 and 512 % OUT_W == 0);
  - a function clog2 for the cnt width.
- The block is a single module with no sub-module. The datapath (two 512-bit registers plus a mux) and the control (three flags plus a counter) are too tightly coupled to split.
- The bench instantiates the existing 512-bit FIFO wrapper feeding this block.

## Test plan
- Reset, then push 1 word 0x…0706050403020100 with OUT_W = 64 and m_ready = 1 → fifo_rd_en high for exactly 1 cycle; m_valid high 2 cycles later for 8 cycles; beats 0x0706050403020100 first; m_last only on beat 7.
- Push 4 words back-to-back with m_ready = 1 → 32 consecutive valid cycles, no gaps; word order preserved.
- Push 3 words, then hold m_ready = 0 for 20 cycles → exactly 2 pops occur, then fifo_rd_en stays 0; output holds beat 0 stable; on release, all 24 beats arrive in order.
- Random m_ready (50%) with 100 random words at OUT_W = 8 and at OUT_W = 256 → scoreboard matches; fifo_rd_en is never high while fifo_empty = 1.
- Assert rst for 1 cycle in the middle of word 2 while a read is pending (FIFO reset together) → next cycle m_valid = 0 and all outputs are 0; new traffic afterwards is correct with no stale beats.
- FIFO drains mid-stream: push 1 word, wait 10 cycles, push 1 more → m_valid drops after the 8th beat; the next beat appears 2 cycles after the new fifo_rd_en.

Source files
------------

// File: rtl/fifo_512_unpack_pkg.sv
// ============================================================================
// Package  : fifo_512_unpack_pkg
// Brief    : Shared word width, OUT_W legality check and counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_512_unpack_pkg;

    localparam int WORD_W = 512;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // At least two beats per word keeps the prefetch path gapless.
    function automatic bit out_w_legal(input int w);
        return (w > 0) && (WORD_W % w == 0) && (WORD_W / w >= 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_512_unpack.sv
// ============================================================================
// Module   : fifo_512_unpack
// Brief    : Pops 512-bit words from a 1-cycle-latency FIFO and serializes
//            them little-endian into OUT_W-bit valid/ready beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_512_unpack
    import fifo_512_unpack_pkg::*;
#(
    parameter int OUT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [511:0]      fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int c_BEATS = WORD_W / OUT_W;
    localparam int c_CNT_W = clog2(c_BEATS);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(c_BEATS - 1);

    if (!out_w_legal(OUT_W)) begin : g_out_w_check
        $error("fifo_512_unpack: illegal OUT_W %0d", OUT_W);
    end

    logic [WORD_W-1:0]  r_active;
    logic [WORD_W-1:0]  r_stage;
    logic               r_active_v;
    logic               r_stage_v;
    logic               r_pending;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_rd_en;
    logic               w_xfer;
    logic               w_last;
    logic               w_free;
    logic [OUT_W-1:0]   w_beats [c_BEATS];

    // A read is only issued when its return is guaranteed a free slot.
    assign w_rd_en = !rst && !fifo_empty && !r_pending && !r_stage_v;
    assign w_xfer  = r_active_v && m_ready;
    assign w_last  = (r_cnt == c_LAST_CNT);
    assign w_free  = !r_active_v || (w_xfer && w_last);

    for (genvar b = 0; b < c_BEATS; b++) begin : g_beats
        assign w_beats[b] = r_active[b*OUT_W +: OUT_W];
    end

    assign fifo_rd_en = w_rd_en;
    assign m_data     = w_beats[r_cnt];
    assign m_valid    = r_active_v;
    assign m_last     = r_active_v && w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active   <= '0;
            r_stage    <= '0;
            r_active_v <= 1'b0;
            r_stage_v  <= 1'b0;
            r_pending  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_pending <= w_rd_en;

            if (w_xfer) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end

            // Stage has priority for the active slot; a concurrent return refills stage.
            if (w_free) begin
                if (r_stage_v) begin
                    r_active   <= r_stage;
                    r_active_v <= 1'b1;
                    r_stage_v  <= r_pending;
                    if (r_pending) begin
                        r_stage <= fifo_dout;
                    end
                end else if (r_pending) begin
                    r_active   <= fifo_dout;
                    r_active_v <= 1'b1;
                end else begin
                    r_active_v <= 1'b0;
                end
            end else if (r_pending) begin
                r_stage   <= fifo_dout;
                r_stage_v <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_512_unpack.sv
// ============================================================================
// Module   : tb_fifo_512_unpack
// Brief    : Drives three widths (64, 8, 256) from FIFO models with shared
//            traffic and checks every beat against a word-splitting model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_512_unpack;

    localparam int NI    = 3;
    localparam int BOUND = 40000;

    function automatic int width_of(input int k);
        return (k == 0) ? 64 : (k == 1) ? 8 : 256;
    endfunction

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         push;
    logic [511:0] push_data;
    logic         m_ready;

    logic [255:0] data_a  [NI];
    logic         valid_a [NI];
    logic         last_a  [NI];
    logic         rd_a    [NI];
    logic         empty_a [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int W = width_of(k);
        logic           fifo_rd_en;
        logic           fifo_empty;
        logic           m_valid;
        logic           m_last;
        logic [W-1:0]   m_data;
        logic [511:0]   fifo_dout = '0;
        logic [511:0]   fq [$];
        int             fcount = 0;

        // Non-FWFT FIFO: data appears the cycle after the pop request.
        always @(posedge clk) begin
            if (rst) begin
                fq.delete();
            end else begin
                if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
                if (push) fq.push_back(push_data);
            end
            fcount <= fq.size();
        end
        assign fifo_empty = (fcount == 0);

        fifo_512_unpack #(.OUT_W(W)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .fifo_dout  (fifo_dout),
            .fifo_empty (fifo_empty),
            .fifo_rd_en (fifo_rd_en),
            .m_data     (m_data),
            .m_valid    (m_valid),
            .m_ready    (m_ready),
            .m_last     (m_last)
        );

        assign data_a[k]  = 256'(m_data);
        assign valid_a[k] = m_valid;
        assign last_a[k]  = m_last;
        assign rd_a[k]    = fifo_rd_en;
        assign empty_a[k] = fifo_empty;
    end

    beat_t        exp_q [NI][$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           rd_cnt = 0, vld_cnt = 0, last_cnt = 0, rise_n = 0, fall_n = 0;
    int           rise_cyc = 0, last_rd_cyc = 0;
    logic [255:0] rise_data = '0;
    logic         prev_vld = 1'b0;
    logic [511:0] wd [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Expected beats: each word split little-endian at every instance width.
    task automatic add_word(input logic [511:0] w);
        for (int k = 0; k < NI; k++) begin
            int bw = width_of(k);
            int nb = 512 / bw;
            logic [255:0] msk;
            msk = '1;
            if (bw < 256) msk = (256'd1 << bw) - 256'd1;
            for (int b = 0; b < nb; b++) begin
                logic [511:0] t;
                beat_t        e;
                t      = w >> (b * bw);
                e.data = t[255:0] & msk;
                e.last = (b == nb - 1);
                exp_q[k].push_back(e);
            end
        end
    endtask

    task automatic scoreboard();
        beat_t e;
        cyc++;
        if (rst) begin
            for (int k = 0; k < NI; k++) exp_q[k].delete();
            prev_vld = 1'b0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                vectors++;
                if (rd_a[k] && empty_a[k]) begin
                    miscompares++;
                    $display("FAIL rd_while_empty w=%0d cyc=%0d: fifo_rd_en=1 required 0", width_of(k), cyc);
                end
                if (valid_a[k]) begin
                    vectors++;
                    if (exp_q[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL spurious_beat w=%0d cyc=%0d: got data %0h required no beat", width_of(k), cyc, data_a[k]);
                    end else begin
                        e = exp_q[k][0];
                        if (data_a[k] !== e.data || last_a[k] !== e.last) begin
                            miscompares++;
                            $display("FAIL beat w=%0d cyc=%0d: got %0h last=%0b required %0h last=%0b",
                                     width_of(k), cyc, data_a[k], last_a[k], e.data, e.last);
                        end
                        if (m_ready) e = exp_q[k].pop_front();
                    end
                end
            end
            if (rd_a[0]) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (valid_a[0]) begin
                vld_cnt++;
                if (!prev_vld) begin
                    rise_n++;
                    rise_cyc  = cyc;
                    rise_data = data_a[0];
                end
                if (last_a[0]) last_cnt++;
            end else if (prev_vld) begin
                fall_n++;
            end
            prev_vld = valid_a[0];
        end
        if (push && !rst) add_word(push_data);
    endtask

    task automatic tick();
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NI; k++) begin
            if (exp_q[k].size() != 0 || valid_a[k] || !empty_a[k] || rd_a[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (!all_idle() && n < BOUND) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= BOUND) begin
            miscompares++;
            $display("FAIL drain_%s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    function automatic logic [511:0] rand_word();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic push_word(input logic [511:0] w);
        push      = 1'b1;
        push_data = w;
        tick();
    endtask

    initial begin
        int rd0, v0, l0, r0, f0, n, left;
        logic [511:0] w0;

        rst = 1'b1; push = 1'b0; push_data = '0; m_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_valid_w%0d", width_of(k)), 256'(valid_a[k]), 256'd0);
            check($sformatf("reset_data_w%0d", width_of(k)), data_a[k], 256'd0);
        end
        check("reset_last", 256'(last_a[0]), 256'd0);
        check("reset_rd_en", 256'(rd_a[0]), 256'd0);

        // Single word with byte i = i.
        for (int i = 0; i < 64; i++) w0[i*8 +: 8] = 8'(i);
        rd0 = rd_cnt; v0 = vld_cnt; l0 = last_cnt;
        push_word(w0);
        repeat (15) tick();
        check("one_word_pops", 256'(rd_cnt - rd0), 256'd1);
        check("one_word_valid_cycles", 256'(vld_cnt - v0), 256'd8);
        check("one_word_last_count", 256'(last_cnt - l0), 256'd1);
        check("one_word_latency", 256'(rise_cyc - last_rd_cyc), 256'd2);
        check("one_word_beat0", rise_data, 256'h0706050403020100);
        drain("one_word");

        // Back-to-back words must stream without a bubble.
        v0 = vld_cnt; r0 = rise_n; f0 = fall_n;
        for (int i = 0; i < 4; i++) push_word(rand_word());
        drain("b2b");
        check("b2b_valid_cycles", 256'(vld_cnt - v0), 256'd32);
        check("b2b_rises", 256'(rise_n - r0), 256'd1);
        check("b2b_falls", 256'(fall_n - f0), 256'd1);

        // Backpressure: only active + stage may be filled.
        m_ready = 1'b0;
        rd0 = rd_cnt; v0 = vld_cnt;
        for (int i = 0; i < 3; i++) begin
            wd[i] = rand_word();
            push_word(wd[i]);
        end
        repeat (20) tick();
        check("hold_pops", 256'(rd_cnt - rd0), 256'd2);
        check("hold_valid", 256'(valid_a[0]), 256'd1);
        check("hold_data_w64", data_a[0], 256'(wd[0][63:0]));
        check("hold_data_w8", data_a[1], 256'(wd[0][7:0]));
        check("hold_data_w256", data_a[2], wd[0][255:0]);
        v0 = vld_cnt;
        m_ready = 1'b1;
        drain("hold");
        check("hold_release_beats", 256'(vld_cnt - v0), 256'd24);
        check("hold_total_pops", 256'(rd_cnt - rd0), 256'd3);

        // Random backpressure and push gaps.
        left = 100;
        n = 0;
        while (left > 0 && n < BOUND) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                push = 1'b1;
                push_data = rand_word();
                left--;
            end
            tick();
            n++;
        end
        n = 0;
        while (!all_idle() && n < BOUND) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_ready = 1'b1;
        drain("random");

        // Reset in the middle of word 2 while the read of word 3 is in flight.
        for (int i = 0; i < 3; i++) push_word(rand_word());
        l0 = last_cnt;
        n = 0;
        while (last_cnt == l0 && n < 200) begin tick(); n++; end
        while (!rd_a[0] && n < 200) begin tick(); n++; end
        check("mid_reset_reached", 256'(n < 200), 256'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_valid", 256'(valid_a[0]), 256'd0);
        check("mid_reset_last", 256'(last_a[0]), 256'd0);
        check("mid_reset_data", data_a[0], 256'd0);
        check("mid_reset_rd_en", 256'(rd_a[0]), 256'd0);
        check("mid_reset_valid_w8", 256'(valid_a[1]), 256'd0);
        v0 = vld_cnt;
        for (int i = 0; i < 2; i++) push_word(rand_word());
        drain("after_reset");
        check("after_reset_beats", 256'(vld_cnt - v0), 256'd16);

        // FIFO runs dry between two words.
        v0 = vld_cnt; f0 = fall_n;
        push_word(rand_word());
        repeat (10) tick();
        push_word(rand_word());
        drain("dry");
        check("dry_valid_cycles", 256'(vld_cnt - v0), 256'd16);
        check("dry_falls", 256'(fall_n - f0), 256'd2);
        check("dry_restart_latency", 256'(rise_cyc - last_rd_cyc), 256'd2);

        for (int k = 0; k < NI; k++) begin
            check($sformatf("leftover_beats_w%0d", width_of(k)), 256'(exp_q[k].size()), 256'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
